// File: rtl/fetch_pair_buffer_pkg.sv
// fetch_pair_buffer_pkg: shared widths, NOP encoding and the queued pair type
// used by the fetch pair buffer and the steer stage downstream of it.
package fetch_pair_buffer_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst0;
        logic [INST_WIDTH-1:0] inst1;
    } fetch_pair_t;

    localparam int PAIR_WIDTH = $bits(fetch_pair_t);

    function automatic fetch_pair_t make_pair(
        input logic [ADDR_WIDTH-1:0] pc,
        input logic [INST_WIDTH-1:0] inst0,
        input logic [INST_WIDTH-1:0] inst1
    );
        fetch_pair_t p;
        p.pc    = pc;
        p.inst0 = inst0;
        p.inst1 = inst1;
        return p;
    endfunction

endpackage

// File: rtl/fetch_pair_ram.sv
// fetch_pair_ram: DEPTH-entry pair storage, one synchronous write port and
// one asynchronous read port; contents are never reset.
module fetch_pair_ram
    import fetch_pair_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  fetch_pair_t              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output fetch_pair_t              rdata_o
);

    fetch_pair_t mem_q [DEPTH];

    // Write the incoming pair into its slot
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_pair_buffer.sv
// fetch_pair_buffer: circular queue of instruction pairs feeding the steer
// stage. Optional same-cycle bypass when empty: define FETCH_BYPASS_EN.
module fetch_pair_buffer
    import fetch_pair_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   imem_valid,
    input  logic [ADDR_WIDTH-1:0]  imem_pc,
    input  logic [INST_WIDTH-1:0]  imem_instruction0,
    input  logic [INST_WIDTH-1:0]  imem_instruction1,
    output logic                   imem_ready,
    input  logic                   flush,
    input  logic                   stall,
    output logic [INST_WIDTH-1:0]  instruction0_out,
    output logic [INST_WIDTH-1:0]  instruction1_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   valid_out,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        empty;
    logic        stored_valid;
    logic        bypass_hit;
    logic        push;
    logic        pop;
    fetch_pair_t in_pair;
    fetch_pair_t head_pair;
    fetch_pair_t out_pair;

    assign in_pair = make_pair(imem_pc, imem_instruction0, imem_instruction1);

    assign empty        = (count_q == '0);
    assign imem_ready   = (count_q < FULL_COUNT) && !flush;
    assign stored_valid = !empty && !flush;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = empty && imem_valid && !flush;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed pair consumed this cycle never needs a slot
    assign push = imem_valid && imem_ready && !(bypass_hit && !stall);
    assign pop  = stored_valid && !stall;

    fetch_pair_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_pair),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_pair)
    );

    // Next pointer/count state; flush clears everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer/count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head pair to steer, NOP when nothing valid
    always_comb begin
        valid_out        = stored_valid || bypass_hit;
        out_pair         = bypass_hit ? in_pair : head_pair;
        instruction0_out = NOP_INSTRUCTION;
        instruction1_out = NOP_INSTRUCTION;
        pc_out           = '0;
        if (valid_out) begin
            instruction0_out = out_pair.inst0;
            instruction1_out = out_pair.inst1;
            pc_out           = out_pair.pc;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb_fetch_pair_buffer: directed and random scenarios checked cycle by cycle
// against a queue model of the fetch pair buffer.
module tb_fetch_pair_buffer;
    import fetch_pair_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] i0;
        logic [INST_WIDTH-1:0] i1;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    logic imem_valid;
    logic [ADDR_WIDTH-1:0] imem_pc;
    logic [INST_WIDTH-1:0] imem_instruction0;
    logic [INST_WIDTH-1:0] imem_instruction1;
    logic imem_ready;
    logic flush;
    logic stall;
    logic [INST_WIDTH-1:0] instruction0_out;
    logic [INST_WIDTH-1:0] instruction1_out;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic valid_out;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail = 0;

    pair_t mq[$];
    logic e_valid;
    logic e_ready;
    logic [ADDR_WIDTH-1:0] e_pc;
    logic [INST_WIDTH-1:0] e_i0;
    logic [INST_WIDTH-1:0] e_i1;
    logic [CW-1:0] e_cnt;

    always #5 clk = ~clk;

    fetch_pair_buffer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_valid        (imem_valid),
        .imem_pc           (imem_pc),
        .imem_instruction0 (imem_instruction0),
        .imem_instruction1 (imem_instruction1),
        .imem_ready        (imem_ready),
        .flush             (flush),
        .stall             (stall),
        .instruction0_out  (instruction0_out),
        .instruction1_out  (instruction1_out),
        .pc_out            (pc_out),
        .valid_out         (valid_out),
        .count             (count)
    );

    task automatic drive(input bit v, input logic [ADDR_WIDTH-1:0] pc,
                         input bit fl, input bit st);
        imem_valid        = v;
        imem_pc           = pc;
        imem_instruction0 = $urandom;
        imem_instruction1 = $urandom;
        flush             = fl;
        stall             = st;
    endtask

    task automatic expect_now();
        int n;
        n       = mq.size();
        e_cnt   = CW'(n);
        e_ready = (n < DEPTH) && !flush;
        e_valid = 1'b0;
        e_pc    = '0;
        e_i0    = NOP_INSTRUCTION;
        e_i1    = NOP_INSTRUCTION;
        if (!flush && n != 0) begin
            e_valid = 1'b1;
            e_pc    = mq[0].pc;
            e_i0    = mq[0].i0;
            e_i1    = mq[0].i1;
        end
`ifdef FETCH_BYPASS_EN
        else if (!flush && imem_valid) begin
            e_valid = 1'b1;
            e_pc    = imem_pc;
            e_i0    = imem_instruction0;
            e_i1    = imem_instruction1;
        end
`endif
    endtask

    task automatic advance();
        int n;
        bit take;
        pair_t p;
        n = mq.size();
        if (flush) begin
            mq.delete();
        end else begin
            take = imem_valid && (n < DEPTH);
`ifdef FETCH_BYPASS_EN
            if (n == 0 && imem_valid && !stall) take = 1'b0;
`endif
            if (n != 0 && !stall) void'(mq.pop_front());
            if (take) begin
                p.pc = imem_pc;
                p.i0 = imem_instruction0;
                p.i1 = imem_instruction1;
                mq.push_back(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        #3;
        n_tests++;
        if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
            !== {1'b0, {ADDR_WIDTH{1'b0}}, NOP_INSTRUCTION, NOP_INSTRUCTION,
                 {CW{1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                     valid_out, pc_out, instruction0_out, instruction1_out,
                     count, imem_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, (i == 0) ? 32'h10 : 32'h12, 1'b0, 1'b0);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL basic c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        bit st;
        for (int i = 0; i < 7; i++) begin
            st = (i == 1 || i == 2);
            drive(i < 2, (i == 0) ? 32'h10 : 32'h12, 1'b0, st);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL stall c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 12; i++) begin
            drive(i < 5, 32'h20 + 32'(2 * i), 1'b0, i < 6);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL full c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        bit v;
        bit fl;
        for (int i = 0; i < 7; i++) begin
            v  = (i <= 4);
            fl = (i == 3);
            drive(v, (i == 4) ? 32'hC0 : 32'h40 + 32'(2 * i), fl, i < 3);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL flush c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            drive(i < 10, 32'h100 + 32'(2 * i), 1'b0, (i % 3) == 1);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL wrap c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_bypass();
        bit v;
        bit st;
        for (int i = 0; i < 5; i++) begin
            v  = (i == 0 || i == 2);
            st = (i == 2);
            drive(v, 32'hD0, 1'b0, st);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL bypass c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h60 + 32'(2 * i), 1'b0, 1'b1);
            advance();
        end
        reset = 1'b1;
        drive(1'b1, 32'h70, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        n_tests++;
        if ({valid_out, count, imem_ready} !== {1'b0, {CW{1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b n=%0d r=%b want v=0 n=0 r=1",
                     valid_out, count, imem_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
            #3;
            expect_now();
            n_tests++;
            if ({valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready}
                !== {e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready}) begin
                n_fail++;
                $display("FAIL random c%0d: got v=%b pc=%h i0=%h i1=%h n=%0d r=%b want v=%b pc=%h i0=%h i1=%h n=%0d r=%b",
                         i, valid_out, pc_out, instruction0_out, instruction1_out, count, imem_ready,
                         e_valid, e_pc, e_i0, e_i1, e_cnt, e_ready);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_flush();
        test_wrap();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pair_buffer.md
# fetch_pair_buffer

Dual-issue fetch buffer sitting directly upstream of the instruction steering stage. It accepts instruction pairs from instruction memory at up to one pair per cycle, queues them, and presents the head pair as `instruction0`/`instruction1` to the steer stage. While the steer stage asserts `stall` to split a conflicting pair, the head pair is held unchanged. A branch redirect (`flush`) discards all queued pairs.

## Interface
Parameters:
- `DEPTH`, default 4: queue capacity in instruction pairs; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_valid` in 1: instruction memory presents a valid pair this cycle.
- `imem_pc` in `ADDR_WIDTH`: address of `imem_instruction0`; `imem_instruction1` is at `imem_pc + 1`.
- `imem_instruction0` in `INST_WIDTH`: older instruction of the incoming pair.
- `imem_instruction1` in `INST_WIDTH`: younger instruction of the incoming pair.
- `imem_ready` out 1: buffer accepts a pair this cycle.
- `flush` in 1: branch redirect; discard everything.
- `stall` in 1: from steer; hold the head pair.
- `instruction0_out` out `INST_WIDTH`: head pair, older; `NOP_INSTRUCTION` when `valid_out`=0.
- `instruction1_out` out `INST_WIDTH`: head pair, younger; `NOP_INSTRUCTION` when `valid_out`=0.
- `pc_out` out `ADDR_WIDTH`: PC of `instruction0_out`; 0 when `valid_out`=0.
- `valid_out` out 1: head pair is valid.
- `count` out `$clog2(DEPTH)+1`: number of pairs stored.

## Operation
- Storage is a circular queue with write pointer `wr_ptr`, read pointer `rd_ptr` (each `$clog2(DEPTH)` bits, wrapping modulo DEPTH), and `count`.
- `imem_ready` = (`count` < DEPTH) && !`flush`. It depends only on registered `count`: a pop in the same cycle does not free a slot when full.
- push = `imem_valid` && `imem_ready`. Writes the pair and PC at `wr_ptr`, then increments `wr_ptr`.
- pop = `valid_out` && !`stall` && !`flush`. Increments `rd_ptr`.
- `count` next = `count` + push − pop. Simultaneous push and pop leaves it unchanged.
- `valid_out` = (`count` != 0) && !`flush`. Outputs are driven combinationally from the entry at `rd_ptr`.
- `flush` has priority over everything:
  - `wr_ptr`, `rd_ptr` and `count` go to 0 next cycle.
  - Any incoming pair is dropped.
  - Outputs show NOP with `valid_out`=0 in the flush cycle.
- `stall` while `valid_out`=1 keeps the same pair, and the same PC, on the outputs the next cycle.
- `stall` while `valid_out`=0 has no effect.
- Pairs are never split or reordered; `instruction0_out` is always older.
- Reset state:
  - Pointers and `count` are 0.
  - `valid_out`=0, `instruction0_out`/`instruction1_out` = `NOP_INSTRUCTION`, `pc_out`=0.
  - `imem_ready`=1 from the first cycle after reset.
  - Storage contents are not cleared.
- Reset asserted mid-operation discards all queued pairs, exactly like `flush`.

## Timing
- Push-to-output latency is 1 cycle when the queue is empty (without bypass).
- Throughput is one pair per cycle in steady state, while `stall`=0 and neither full nor empty.
- A single `stall` cycle causes one cycle of head hold. Back-to-back `stall` holds for each stalled cycle.
- After `flush`, the first new pair can be pushed in the following cycle.
- Full queue: `imem_ready`=0 until a pop reduces `count`, then `imem_ready`=1 in the next cycle.

## Configuration
- `FETCH_BYPASS_EN` defined, when `count`=0, `imem_valid`=1 and `flush`=0:
  - The incoming pair drives the outputs in the same cycle, with `valid_out`=1.
  - If `stall`=0, the pair is consumed without being written (`count` stays 0).
  - If `stall`=1, the pair is written as a normal push and is presented again next cycle.
- `FETCH_BYPASS_EN` undefined: no combinational path from `imem_*` to the outputs; minimum latency is 1 cycle.

## Structure
- `INST_WIDTH`, `ADDR_WIDTH` and `NOP_INSTRUCTION` come from the shared defines header used by the steer stage. No new constants are added there.
- Sub-module `fetch_pair_ram`:
  - DEPTH × (2·`INST_WIDTH` + `ADDR_WIDTH`) register array.
  - One synchronous write port and one asynchronous read port.
  - No reset on the contents.
- Pointer, count, ready, valid and bypass logic live in `fetch_pair_buffer`.

## Test plan
- Reset, then push pairs A (pc 0x10), B (pc 0x12) with `stall`=0 → outputs A then B on consecutive cycles, `count` returns to 0, `valid_out` drops to 0 with NOP outputs.
- Push A, B; assert `stall` for 2 cycles while A is at the head → A held for 3 cycles total (`pc_out`=0x10), then B appears; nothing lost.
- Fill DEPTH=4 with `stall`=1 → `count`=4, `imem_ready`=0, and a fifth pair offered is not accepted. Release `stall` → drains in order; `imem_ready` returns 1 the cycle after the first pop.
- Queue 3 pairs, assert `flush` together with `imem_valid` → the incoming pair is dropped, `valid_out`=0 in that cycle, `count`=0 next cycle; a new pair C is pushed next cycle and appears at the output one cycle later.
- Run 10 pushes and pops interleaved so the pointers wrap past DEPTH → output order and PCs match the input sequence exactly.
- With `FETCH_BYPASS_EN`: empty queue, push D with `stall`=0 → D is on the outputs in the same cycle and `count` stays 0. Repeat with `stall`=1 → D is shown and `count`=1, and D is shown again the next cycle.
